// File: rtl/x_stack.sv
`default_nettype none
// ============================================================================
//  Module      : x_stack
//  Description : LIFO of {activation vector, interweave trit} entries. The
//                forward pass pushes each layer input; the backward pass pops
//                them back in reverse order so the backprop stage sees x
//                before its trit is applied.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    X_SIZE    : activation vector width in bits
//    TRIT_SIZE : width of the per-layer interweave trit index
//    DEPTH     : maximum number of stored layers (power of two, >= 2)
//  Ports
//    clk_in                    : clock, all state updates on the rising edge
//    rst_n_in                  : asynchronous active-low reset
//    push_valid/ready/x/trit   : forward-pass entry (valid/ready handshake)
//    pop_valid/ready/x/trit    : backward-pass entry, top of stack shown
//                                combinationally; zeros when empty
//    count                     : number of stored entries (0..DEPTH)
//    full, empty               : count == DEPTH, count == 0
//    bwd                       : 1 while in the backward-pass state
//    err                       : sticky protocol (or parity) error flag
//  Optional feature
//    X_STACK_PARITY_EN : when defined, each entry carries an extra parity bit
//                        (XOR of x and trit) that is rechecked on every
//                        accepted pop; a mismatch sets err.
// ============================================================================
module x_stack #(
  parameter int unsigned X_SIZE    = 1024,
  parameter int unsigned TRIT_SIZE = 4,
  parameter int unsigned DEPTH     = 16
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     push_valid,
  output logic                     push_ready,
  input  logic [X_SIZE-1:0]        push_x,
  input  logic [TRIT_SIZE-1:0]     push_trit,
  output logic                     pop_valid,
  input  logic                     pop_ready,
  output logic [X_SIZE-1:0]        pop_x,
  output logic [TRIT_SIZE-1:0]     pop_trit,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     bwd,
  output logic                     err
);

  localparam int unsigned C_AW = $clog2(DEPTH);
  localparam int unsigned C_CW = C_AW + 1;
`ifdef X_STACK_PARITY_EN
  localparam int unsigned C_EW = X_SIZE + TRIT_SIZE + 1;
`else
  localparam int unsigned C_EW = X_SIZE + TRIT_SIZE;
`endif

  localparam logic [C_CW-1:0] C_ONE   = C_CW'(1);
  localparam logic [C_CW-1:0] C_FULL  = C_CW'(DEPTH);
  localparam logic [C_AW-1:0] C_IDX1  = C_AW'(1);

  localparam logic [0:0] S_FWD = 1'b0;
  localparam logic [0:0] S_BWD = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [C_CW-1:0]  count_q, count_d;
  logic             err_q, err_d;
  logic [C_EW-1:0]  mem_q [DEPTH];

  logic             push_acc;
  logic             pop_acc;
  logic [C_AW-1:0]  wr_idx;
  logic [C_AW-1:0]  top_idx;
  logic [C_EW-1:0]  wr_entry_d;
  logic [C_EW-1:0]  top_entry;
  logic             par_err;

  // --------------------------------------------------------------------------
  // Status
  // --------------------------------------------------------------------------
  assign full      = (count_q == C_FULL);
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign err       = err_q;
  assign pop_valid = !empty;

  assign push_acc  = push_valid && push_ready;
  assign pop_acc   = pop_valid && pop_ready;

  // Index arithmetic is modulo DEPTH; with count == DEPTH the top entry wraps
  // correctly to DEPTH-1, and an empty stack's top index is masked below.
  assign wr_idx    = count_q[C_AW-1:0];
  assign top_idx   = count_q[C_AW-1:0] - C_IDX1;
  assign top_entry = mem_q[top_idx];

  assign pop_x     = empty ? '0 : top_entry[X_SIZE-1:0];
  assign pop_trit  = empty ? '0 : top_entry[X_SIZE +: TRIT_SIZE];

`ifdef X_STACK_PARITY_EN
  assign wr_entry_d = {^{push_x, push_trit}, push_trit, push_x};
  assign par_err    = pop_acc && (top_entry[C_EW-1] != ^top_entry[C_EW-2:0]);
`else
  assign wr_entry_d = {push_trit, push_x};
  assign par_err    = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= S_FWD;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state. Any pop enters BWD, but the pop that empties the stack
  // returns to FWD, so a single-entry pop from FWD lands straight back in FWD.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (pop_acc) begin
      state_d = (count_q == C_ONE) ? S_FWD : S_BWD;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: outputs. In FWD a pending pop blocks the push so the pop always wins.
  // --------------------------------------------------------------------------
  always_comb begin
    push_ready = 1'b0;
    bwd        = 1'b0;
    case (state_q)
      S_FWD: push_ready = !full && !(pop_ready && !empty);
      S_BWD: bwd        = 1'b1;
      default: begin
        push_ready = 1'b0;
        bwd        = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Count and sticky error
  // --------------------------------------------------------------------------
  always_comb begin
    count_d = count_q;
    if (pop_acc) begin
      count_d = count_q - C_ONE;
    end else if (push_acc) begin
      count_d = count_q + C_ONE;
    end

    err_d = err_q;
    if (push_valid && ((state_q == S_BWD) || full)) begin
      err_d = 1'b1;
    end
    if (pop_ready && empty) begin
      err_d = 1'b1;
    end
    if (par_err) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // --------------------------------------------------------------------------
  // Entry storage: not reset, since entries at or above count are don't-care.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (push_acc) begin
      mem_q[wr_idx] <= wr_entry_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_x_stack.sv
`default_nettype none
// ============================================================================
//  Module      : tb_x_stack
//  Description : Self-checking bench for x_stack with a queue-based LIFO
//                reference model and directed plus randomized scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_x_stack;

  localparam int unsigned XS = 1024;
  localparam int unsigned TS = 4;
  localparam int unsigned DP = 16;

  logic           clk_in = 1'b0;
  logic           rst_n_in = 1'b0;
  logic           push_valid = 1'b0;
  logic           push_ready;
  logic [XS-1:0]  push_x = '0;
  logic [TS-1:0]  push_trit = '0;
  logic           pop_valid;
  logic           pop_ready = 1'b0;
  logic [XS-1:0]  pop_x;
  logic [TS-1:0]  pop_trit;
  logic [4:0]     count;
  logic           full;
  logic           empty;
  logic           bwd;
  logic           err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain queues plus the two visible flags.
  logic [XS-1:0] mq_x[$];
  logic [TS-1:0] mq_t[$];
  bit            m_bwd;
  bit            m_err;

  x_stack #(.X_SIZE(XS), .TRIT_SIZE(TS), .DEPTH(DP)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .push_valid(push_valid), .push_ready(push_ready),
    .push_x(push_x), .push_trit(push_trit),
    .pop_valid(pop_valid), .pop_ready(pop_ready),
    .pop_x(pop_x), .pop_trit(pop_trit),
    .count(count), .full(full), .empty(empty), .bwd(bwd), .err(err)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [XS-1:0] rand_x();
    logic [XS-1:0] v;
    for (int i = 0; i < XS/32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic bit m_push_ready();
    return !m_bwd && (mq_x.size() < DP) && !(pop_ready && mq_x.size() != 0);
  endfunction

  function automatic logic [XS-1:0] m_top_x();
    return (mq_x.size() == 0) ? '0 : mq_x[mq_x.size()-1];
  endfunction

  function automatic logic [TS-1:0] m_top_t();
    return (mq_t.size() == 0) ? '0 : mq_t[mq_t.size()-1];
  endfunction

  task automatic drive(input bit pv, input logic [XS-1:0] px, input logic [TS-1:0] pt, input bit pr);
    push_valid = pv;
    push_x     = px;
    push_trit  = pt;
    pop_ready  = pr;
    #1;
  endtask

  // Advances one clock, applying the stack rules to the model from the inputs
  // currently driven.
  task automatic tick();
    int  n;
    bit  pa;
    bit  qa;
    n  = mq_x.size();
    qa = pop_ready && (n != 0);
    pa = push_valid && m_push_ready();
    if (push_valid && (m_bwd || n == DP)) m_err = 1'b1;
    if (pop_ready && n == 0) m_err = 1'b1;
    @(posedge clk_in);
    if (qa) begin
      void'(mq_x.pop_back());
      void'(mq_t.pop_back());
      m_bwd = (mq_x.size() != 0);
    end else if (pa) begin
      mq_x.push_back(push_x);
      mq_t.push_back(push_trit);
    end
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, '0, '0, 1'b0);
    rst_n_in = 1'b0;
    mq_x.delete();
    mq_t.delete();
    m_bwd = 1'b0;
    m_err = 1'b0;
    @(negedge clk_in);
    rst_n_in = 1'b1;
    @(posedge clk_in);
    #1;
  endtask

  task automatic push_one(input logic [XS-1:0] px, input logic [TS-1:0] pt);
    drive(1'b1, px, pt, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0);
  endtask

  task automatic pop_one();
    drive(1'b0, '0, '0, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b0);
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    rst_n_in = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    #3;
    n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got=%b exp=1", empty); end
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%b exp=0", full); end
    n_checks++; if (pop_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pop_valid got=%b exp=0", pop_valid); end
    n_checks++; if (bwd !== 1'b0) begin n_fail++; $display("FAIL reset_bwd got=%b exp=0", bwd); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", err); end
    do_reset();
    n_checks++; if (push_ready !== 1'b1) begin n_fail++; $display("FAIL reset_push_ready got=%b exp=1", push_ready); end
    n_checks++; if (pop_x !== '0) begin n_fail++; $display("FAIL reset_pop_x got=%h exp=0", pop_x[63:0]); end
  endtask

  task automatic test_basic_lifo();
    logic [XS-1:0] ex;
    do_reset();
    for (int i = 1; i <= 3; i++) push_one(XS'(i), TS'(i-1));
    n_checks++; if (count !== 5'd3) begin n_fail++; $display("FAIL basic_count got=%0d exp=3", count); end
    for (int i = 3; i >= 1; i--) begin
      ex = XS'(i);
      n_checks++; if (pop_x !== ex) begin n_fail++; $display("FAIL basic_pop_x got=%h exp=%h", pop_x[63:0], ex[63:0]); end
      n_checks++; if (pop_trit !== TS'(i-1)) begin n_fail++; $display("FAIL basic_pop_trit got=%0d exp=%0d", pop_trit, i-1); end
      pop_one();
      n_checks++; if (bwd !== (i != 1)) begin n_fail++; $display("FAIL basic_bwd got=%b exp=%b", bwd, (i != 1)); end
    end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL basic_empty got=%b exp=1", empty); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL basic_err got=%b exp=0", err); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < DP; i++) push_one(rand_x(), TS'($urandom()));
    drive(1'b1, rand_x(), 4'h7, 1'b0);
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL ovf_full got=%b exp=1", full); end
    n_checks++; if (push_ready !== 1'b0) begin n_fail++; $display("FAIL ovf_push_ready got=%b exp=0", push_ready); end
    tick();
    drive(1'b0, '0, '0, 1'b0);
    n_checks++; if (count !== 5'd16) begin n_fail++; $display("FAIL ovf_count got=%0d exp=16", count); end
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL ovf_err got=%b exp=1", err); end
    n_checks++; if (pop_x !== m_top_x()) begin n_fail++; $display("FAIL ovf_top_x got=%h", pop_x[63:0]); end
  endtask

  task automatic test_push_in_bwd();
    do_reset();
    push_one(XS'(32'hA1), 4'h1);
    push_one(XS'(32'hB2), 4'h2);
    pop_one();
    drive(1'b1, XS'(32'hC3), 4'h3, 1'b0);
    n_checks++; if (push_ready !== 1'b0) begin n_fail++; $display("FAIL bwdpush_ready got=%b exp=0", push_ready); end
    tick();
    drive(1'b0, '0, '0, 1'b0);
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL bwdpush_err got=%b exp=1", err); end
    n_checks++; if (count !== 5'd1) begin n_fail++; $display("FAIL bwdpush_count got=%0d exp=1", count); end
    n_checks++; if (pop_x !== XS'(32'hA1)) begin n_fail++; $display("FAIL bwdpush_top got=%h exp=a1", pop_x[63:0]); end
    pop_one();
    n_checks++; if (bwd !== 1'b0) begin n_fail++; $display("FAIL bwdpush_bwd got=%b exp=0", bwd); end
    n_checks++; if (push_ready !== 1'b1) begin n_fail++; $display("FAIL bwdpush_ready_after got=%b exp=1", push_ready); end
  endtask

  task automatic test_push_pop_same_cycle();
    do_reset();
    push_one(XS'(32'h11), 4'h1);
    drive(1'b1, XS'(32'h22), 4'h2, 1'b1);
    n_checks++; if (push_ready !== 1'b0) begin n_fail++; $display("FAIL same_push_ready got=%b exp=0", push_ready); end
    n_checks++; if (pop_valid !== 1'b1) begin n_fail++; $display("FAIL same_pop_valid got=%b exp=1", pop_valid); end
    tick();
    drive(1'b0, '0, '0, 1'b0);
    n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL same_count got=%0d exp=0", count); end
    n_checks++; if (pop_x !== '0) begin n_fail++; $display("FAIL same_pop_x got=%h exp=0", pop_x[63:0]); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL same_err got=%b exp=0", err); end
    n_checks++; if (bwd !== 1'b0) begin n_fail++; $display("FAIL same_bwd got=%b exp=0", bwd); end
  endtask

  task automatic test_async_reset();
    do_reset();
    pop_one();
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL areset_underflow_err got=%b exp=1", err); end
    for (int i = 0; i < 4; i++) push_one(rand_x(), TS'(i));
    n_checks++; if (count !== 5'd4) begin n_fail++; $display("FAIL areset_count_pre got=%0d exp=4", count); end
    #1;
    rst_n_in = 1'b0;
    #1;
    n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL areset_count got=%0d exp=0", count); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL areset_empty got=%b exp=1", empty); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL areset_err got=%b exp=0", err); end
    do_reset();
  endtask

  task automatic test_parity();
    bit exp_err;
    do_reset();
    push_one(XS'(32'h5), 4'h0);
`ifdef X_STACK_PARITY_EN
    dut.mem_q[0][0] = ~dut.mem_q[0][0];
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
    n_checks++; if (pop_x !== XS'(32'h5)) begin n_fail++; $display("FAIL parity_pop_x got=%h exp=5", pop_x[63:0]); end
`endif
    pop_one();
    n_checks++; if (err !== exp_err) begin n_fail++; $display("FAIL parity_err got=%b exp=%b", err, exp_err); end
  endtask

  task automatic test_random();
    bit            pv;
    bit            pr;
    logic [XS-1:0] ex;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      // Alternate push-heavy and pop-heavy phases so the stack reaches both ends.
      if (((c / 50) % 2) == 0) begin
        pv = ($urandom_range(0, 3) != 0);
        pr = ($urandom_range(0, 5) == 0);
      end else begin
        pv = ($urandom_range(0, 4) == 0);
        pr = ($urandom_range(0, 2) != 0);
      end
      drive(pv, rand_x(), TS'($urandom()), pr);
      ex = m_top_x();
      n_checks++; if (push_ready !== m_push_ready()) begin n_fail++; $display("FAIL rnd_push_ready c=%0d got=%b exp=%b", c, push_ready, m_push_ready()); end
      n_checks++; if (pop_valid !== (mq_x.size() != 0)) begin n_fail++; $display("FAIL rnd_pop_valid c=%0d got=%b", c, pop_valid); end
      n_checks++; if (pop_x !== ex) begin n_fail++; $display("FAIL rnd_pop_x c=%0d got=%h exp=%h", c, pop_x[63:0], ex[63:0]); end
      n_checks++; if (pop_trit !== m_top_t()) begin n_fail++; $display("FAIL rnd_pop_trit c=%0d got=%0d exp=%0d", c, pop_trit, m_top_t()); end
      tick();
      n_checks++; if (count !== 5'(mq_x.size())) begin n_fail++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, count, mq_x.size()); end
      n_checks++; if (full !== (mq_x.size() == DP)) begin n_fail++; $display("FAIL rnd_full c=%0d got=%b", c, full); end
      n_checks++; if (bwd !== m_bwd) begin n_fail++; $display("FAIL rnd_bwd c=%0d got=%b exp=%b", c, bwd, m_bwd); end
      n_checks++; if (err !== m_err) begin n_fail++; $display("FAIL rnd_err c=%0d got=%b exp=%b", c, err, m_err); end
    end
    drive(1'b0, '0, '0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic_lifo();
    test_overflow();
    test_push_in_bwd();
    test_push_pop_same_cycle();
    test_async_reset();
    test_parity();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
